fp_align: RTL and testbench

FP_ALIGN -- requirements
Module: fp_align

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_unpack.sv | 21 ++
 rtl/fp_align.sv | 126 ++++++++++++
 tb/tb_fp_align.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and field widths for the single-precision align stage
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int BIAS   = 127;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp_eff;
    logic [MANT_W-1:0] mant;
    logic              exp_zero;
    logic              special;
  } unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - splits one IEEE-754 single into sign, effective exponent, mantissa, Inf/NaN flag
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] op,
  output unpacked_t   fields
);

  logic [EXP_W-1:0] exp_field;

  always_comb begin
    exp_field       = op[FRAC_W +: EXP_W];
    fields.sign     = op[31];
    fields.exp_zero = (exp_field == '0);
    // Denormals carry no hidden bit but share the exponent of the smallest normal.
    fields.mant     = {!fields.exp_zero, op[FRAC_W-1:0]};
    fields.exp_eff  = fields.exp_zero ? EXP_W'(1) : exp_field;
    fields.special  = (exp_field == EXP_SPECIAL);
  end

endmodule

// File: rtl/fp_align.sv
// rtl/fp_align.sv - serial exponent alignment of two singles ahead of the mantissa adder
module fp_align
  import fp_pkg::*;
#(
  parameter int MAX_SHIFT = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  input  logic              plus_or_minus,
  output logic [MANT_W-1:0] mant_a,
  output logic [MANT_W-1:0] mant_b,
  output logic              sign_a,
  output logic              sign_b,
  output logic              pm_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sticky,
  output logic              special,
  output logic              busy,
  output logic              ready
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);

  state_t           state, next_state;
  logic [31:0]      op_a_q, op_b_q;
  logic             pm_q;
  logic [CNT_W-1:0] cnt;
  logic             shift_b;

  unpacked_t        ua, ub;
  logic             a_ge;
  logic [EXP_W-1:0] diff_raw, exp_max;
  logic [CNT_W-1:0] diff;

  fp_unpack u_unpack_a (.op(op_a_q), .fields(ua));
  fp_unpack u_unpack_b (.op(op_b_q), .fields(ub));

  always_comb begin
    a_ge     = (ua.exp_eff >= ub.exp_eff);
    diff_raw = a_ge ? (ua.exp_eff - ub.exp_eff) : (ub.exp_eff - ua.exp_eff);
    exp_max  = a_ge ? ua.exp_eff : ub.exp_eff;
    // Past MAX_SHIFT the smaller mantissa is already all zeros, so more shifts add nothing.
    diff     = (diff_raw > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : CNT_W'(diff_raw);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else if (en) state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) next_state = ST_LOAD;
      ST_LOAD: begin
        if (ua.special || ub.special || diff == '0) next_state = ST_DONE;
        else next_state = ST_SHIFT;
      end
      ST_SHIFT: if (cnt == CNT_W'(1)) next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      pm_q    <= 1'b0;
      cnt     <= '0;
      shift_b <= 1'b0;
      mant_a  <= '0;
      mant_b  <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      pm_out  <= 1'b0;
      exp_out <= '0;
      sticky  <= 1'b0;
      special <= 1'b0;
      ready   <= 1'b0;
    end else if (en) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_a_q <= op_a;
            op_b_q <= op_b;
            pm_q   <= plus_or_minus;
            ready  <= 1'b0;
          end else begin
            ready  <= (state == ST_DONE);
          end
        end
        ST_LOAD: begin
          mant_a  <= ua.mant;
          mant_b  <= ub.mant;
          sign_a  <= ua.sign;
          sign_b  <= ub.sign;
          pm_out  <= pm_q;
          exp_out <= (ua.exp_zero && ub.exp_zero) ? '0 : exp_max;
          sticky  <= 1'b0;
          special <= ua.special || ub.special;
          cnt     <= diff;
          shift_b <= a_ge;
        end
        ST_SHIFT: begin
          // Operands keep their ports; only the smaller-exponent side moves.
          if (shift_b) begin
            mant_b <= mant_b >> 1;
            sticky <= sticky | mant_b[0];
          end else begin
            mant_a <= mant_a >> 1;
            sticky <= sticky | mant_a[0];
          end
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_LOAD) || (state == ST_SHIFT);

endmodule

// File: tb/tb_fp_align.sv
// tb/tb_fp_align.sv - directed self-checking bench for fp_align
module tb_fp_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        plus_or_minus;
  logic [23:0] mant_a, mant_b;
  logic        sign_a, sign_b, pm_out;
  logic [7:0]  exp_out;
  logic        sticky, special, busy, ready;

  int tests  = 0;
  int errors = 0;

  fp_align #(.MAX_SHIFT(25)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .op_a(op_a), .op_b(op_b), .plus_or_minus(plus_or_minus),
    .mant_a(mant_a), .mant_b(mant_b), .sign_a(sign_a), .sign_b(sign_b),
    .pm_out(pm_out), .exp_out(exp_out), .sticky(sticky), .special(special),
    .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {mant_a, mant_b, exp_out, sign_a, sign_b, pm_out, sticky, special, busy, ready}, 64'd0);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic pm);
    @(negedge clk);
    op_a = a; op_b = b; plus_or_minus = pm; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("ready_clear", ready, 0);
  endtask

  task automatic wait_ready(input int off_at, input int off_len, input int pulse_at, output int lat);
    lat = 0;
    while (!ready && lat < 100) begin
      en = !(lat >= off_at && lat < off_at + off_len);
      if (lat == pulse_at) begin
        op_a = 32'h3FC00000; op_b = 32'h3F400000; plus_or_minus = 1'b1; start = 1'b1;
      end
      @(posedge clk);
      #1 lat++;
      start = 1'b0;
    end
    en = 1'b1;
    check("ready_timeout", ready, 1);
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b, input logic pm,
                          input int exp_lat, input logic [23:0] ma, input logic [23:0] mb,
                          input logic [7:0] e, input logic st, input logic sp,
                          input logic sa, input logic sb,
                          input int off_at, input int off_len, input int pulse_at);
    int lat;
    start_op(a, b, pm);
    wait_ready(off_at, off_len, pulse_at, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_mant_a"}, mant_a, ma);
    check({tag, "_mant_b"}, mant_b, mb);
    check({tag, "_exp"}, exp_out, e);
    check({tag, "_sticky"}, sticky, st);
    check({tag, "_special"}, special, sp);
    check({tag, "_sign_pm"}, {sign_a, sign_b, pm_out}, {sa, sb, pm});
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; start = 1'b0;
    op_a = '0; op_b = '0; plus_or_minus = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_state");
    @(negedge clk) rst = 1'b1;

    // 1.5 + 0.75: one shift, nothing lost
    op_check("diff1", 32'h3FC00000, 32'h3F400000, 1'b0, 3, 24'hC00000, 24'h600000, 8'h7F, 0, 0, 0, 0, 1000, 0, -1);
    // 2^24 vs 1.0: hidden bit of B ends in sticky
    op_check("diff24", 32'h4B800000, 32'h3F800000, 1'b0, 26, 24'h800000, 24'h000000, 8'h97, 1, 0, 0, 0, 1000, 0, -1);
    // zero vs 2.0: exponent gap saturates at 25
    op_check("sat25", 32'h00000000, 32'h40000000, 1'b0, 27, 24'h000000, 24'h800000, 8'h80, 0, 0, 0, 0, 1000, 0, -1);
    // +Inf bypasses alignment
    op_check("inf", 32'h7F800000, 32'h3F800000, 1'b1, 2, 24'h800000, 24'h800000, 8'hFF, 0, 1, 0, 0, 1000, 0, -1);
    // -2.0 - 1.0, signs carried through
    op_check("signs", 32'hC0000000, 32'h3F800000, 1'b1, 3, 24'h800000, 24'h400000, 8'h80, 0, 0, 1, 0, 1000, 0, -1);
    // A smaller: A shifts by 2, order kept, low 1 goes to sticky
    op_check("a_small", 32'h3F800001, 32'h40800000, 1'b0, 4, 24'h200000, 24'h800000, 8'h81, 1, 0, 0, 0, 1000, 0, -1);
    // two denormals: no shift, exponent reported as 0
    op_check("denorm", 32'h00000001, 32'h80000002, 1'b0, 2, 24'h000001, 24'h000002, 8'h00, 0, 0, 0, 1, 1000, 0, -1);

    // reset in the middle of a long shift
    start_op(32'h4B800000, 32'h3F800000, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_all_zero("rst_mid_shift");
    repeat (2) @(posedge clk);
    #1 check_all_zero("rst_held");
    @(negedge clk) rst = 1'b1;
    op_check("after_rst", 32'h3FC00000, 32'h3F400000, 1'b0, 3, 24'hC00000, 24'h600000, 8'h7F, 0, 0, 0, 0, 1000, 0, -1);

    // enable dropped for 5 cycles mid-shift, stray start during shift
    op_check("stall", 32'h4B800000, 32'h3F800000, 1'b0, 31, 24'h800000, 24'h000000, 8'h97, 1, 0, 0, 0, 5, 5, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", tests, errors);
    $finish;
  end

endmodule
